// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and lane helpers for the multi-cycle data memory controller.
package data_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        size_e       size;
        logic        sign_ext;
        logic [31:0] wdata;
    } req_t;

    // Reserved size behaves as a word access everywhere below.
    function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
        case (sz)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return lo[0];
            default:   return lo != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] lo);
        case (sz)
            SIZE_BYTE: return 4'b0001 << lo;
            SIZE_HALF: return lo[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    // Replicate right-aligned store data onto every lane; byte enables pick the target.
    function automatic logic [31:0] lane_data(input size_e sz, input logic [31:0] wd);
        case (sz)
            SIZE_BYTE: return {4{wd[7:0]}};
            SIZE_HALF: return {2{wd[15:0]}};
            default:   return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input size_e sz, input logic [1:0] lo,
                                                 input logic sx, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (sz)
            SIZE_BYTE: return {{24{sx & b[7]}}, b};
            SIZE_HALF: return {{16{sx & h[15]}}, h};
            default:   return word;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_mem_array.sv
// Single-port DEPTH x 32 RAM: byte-enabled synchronous write, combinational read.
module data_mem_ctrl_mem_array #(
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata_c
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata_c = mem[idx];

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory controller: request latch, wait-state counter,
// lane merge on store and extension on load, feeding the MDR.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           addr,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  mem_ready,
    output logic                  misalign
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    state_e          state;
    logic [CW-1:0]   cnt;
    req_t            req_q;

    logic [AW-1:0]   idx_c;
    logic [31:0]     rword_c;
    logic [31:0]     wlane_c;
    logic [3:0]      be_c;
    logic            mis_c;
    logic            fire_c;
    logic            we_c;

    // Upper address bits fall away in the shift-and-truncate: addresses wrap modulo DEPTH words.
    assign idx_c   = AW'(req_q.addr >> 2);
    assign mis_c   = is_misaligned(req_q.size, req_q.addr[1:0]);
    assign be_c    = byte_en(req_q.size, req_q.addr[1:0]);
    assign wlane_c = lane_data(req_q.size, req_q.wdata);
    assign fire_c  = (state == BUSY) && (cnt == '0) && !rst;
    assign we_c    = fire_c && req_q.write && !mis_c;

    data_mem_ctrl_mem_array #(
        .DEPTH(DEPTH)
    ) u_mem_array (
        .clk     (clk),
        .we      (we_c),
        .be      (be_c),
        .idx     (idx_c),
        .wdata   (wlane_c),
        .rdata_c (rword_c)
    );

    // Request FSM with registered completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_q     <= '0;
            read_data <= '0;
            mem_ready <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            misalign  <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        req_q.write    <= mem_write;
                        req_q.addr     <= addr;
                        req_q.size     <= size_e'(size);
                        req_q.sign_ext <= sign_ext;
                        req_q.wdata    <= 32'(write_data);
                        cnt            <= CW'(WAIT_STATES);
                        state          <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        mem_ready <= 1'b1;
                        misalign  <= mis_c;
                        if (!mis_c && !req_q.write) begin
                            read_data <= DATA_WIDTH'(load_extract(req_q.size, req_q.addr[1:0],
                                                                  req_q.sign_ext, rword_c));
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
